// File: rtl/uart_receiver.sv
// UART receive path: 8N1 idle-high frames recovered from an oversampling baud tick.
// Presents each byte with data-available, framing-error and overrun flags.
module uart_receiver #(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_enable,
    input  logic              rxd,
    input  logic              r_ack,
    output logic [DATA_W-1:0] rx_data,
    output logic              rda,
    output logic              ferr,
    output logic              oerr
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state, state_n;
    logic              sync1, rxs, rxs_d;
    logic [TW-1:0]     tick, tick_n;
    logic [BW-1:0]     bitc, bitc_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
            state <= IDLE;
            tick  <= '0;
            bitc  <= '0;
            shreg <= '0;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
            rxs_d <= rxs;
            state <= state_n;
            tick  <= tick_n;
            bitc  <= bitc_n;
            shreg <= shreg_n;
        end
    end

    always_comb begin
        state_n = state;
        tick_n  = tick;
        bitc_n  = bitc;
        shreg_n = shreg;
        done    = 1'b0;
        case (state)
            IDLE: begin
                tick_n = '0;
                bitc_n = '0;
                // A held-low line after a break needs a fresh 1->0 edge to re-arm.
                if (rxs_d && !rxs) state_n = START;
            end
            START: begin
                if (baud_enable) begin
                    if (tick == HALF_M1) begin
                        tick_n  = '0;
                        state_n = rxs ? IDLE : DATA;
                    end else begin
                        tick_n = tick + 1'b1;
                    end
                end
            end
            DATA: begin
                if (baud_enable) begin
                    if (tick == FULL_M1) begin
                        tick_n  = '0;
                        shreg_n = {rxs, shreg[DATA_W-1:1]};
                        if (bitc == LAST_BIT) begin
                            bitc_n  = '0;
                            state_n = STOP;
                        end else begin
                            bitc_n = bitc + 1'b1;
                        end
                    end else begin
                        tick_n = tick + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_enable) begin
                    if (tick == FULL_M1) begin
                        tick_n  = '0;
                        done    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        tick_n = tick + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Frame completion takes priority over a coincident r_ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data <= '0;
            rda     <= 1'b0;
            ferr    <= 1'b0;
            oerr    <= 1'b0;
        end else if (done) begin
            rx_data <= shreg;
            rda     <= 1'b1;
            ferr    <= ~rxs;
            oerr    <= rda & ~r_ack;
        end else if (r_ack) begin
            rda  <= 1'b0;
            ferr <= 1'b0;
            oerr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: vector table, hand-written corner sequences,
// and randomized frames checked against a frame-level reference model.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_enable;
    logic       rxd;
    logic       r_ack;
    logic [7:0] rx_data;
    logic       rda;
    logic       ferr;
    logic       oerr;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int          bcnt  = 0;
    int          last_rise;
    int          lat_ref;

    logic [7:0] m_data;
    logic       m_rda, m_ferr, m_oerr;

    typedef struct {
        logic [7:0] b;
        logic       stopv;
        int         hold;
        logic       ack;
        logic [7:0] e_data;
        logic       e_rda;
        logic       e_ferr;
        logic       e_oerr;
    } vec_t;

    vec_t tbl[6];

    uart_receiver #(.DATA_W(8), .OVERSAMPLE(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_enable(baud_enable),
        .rxd        (rxd),
        .r_ack      (r_ack),
        .rx_data    (rx_data),
        .rda        (rda),
        .ferr       (ferr),
        .oerr       (oerr)
    );

    always #5 clk = ~clk;

    initial begin
        baud_enable = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bcnt++;
            baud_enable = (bcnt % 4 == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int v, input int lo, input int hi);
        n_cmp++;
        if (v < lo || v > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] d, input logic a,
                                 input logic f, input logic o);
        check({tag, "_data"}, 32'(rx_data), 32'(d));
        check({tag, "_rda"},  32'(rda),     32'(a));
        check({tag, "_ferr"}, 32'(ferr),    32'(f));
        check({tag, "_oerr"}, 32'(oerr),    32'(o));
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_ack();
        r_ack = 1'b1;
        @(posedge clk);
        #2;
        r_ack = 1'b0;
    endtask

    // Drives one frame aligned to a fixed baud phase; cycle c is the edge that follows the drive.
    task automatic drive_frame(input logic [7:0] b, input logic stopv, input int hold,
                               input int ack_off, input int abort_at);
        int         total;
        logic [9:0] bits;
        logic [9:0] sh;
        logic       prev;
        total     = 64 * (11 + hold);
        bits      = {stopv, b, 1'b0};
        last_rise = -1;
        @(posedge clk);
        #2;
        while (bcnt % 4 != 0) begin
            @(posedge clk);
            #2;
        end
        for (int c = 0; c < total; c++) begin
            if (c == abort_at) begin
                r_ack = 1'b0;
                return;
            end
            if (c < 640) begin
                sh  = bits >> (c / 64);
                rxd = sh[0];
            end else if (c < 640 + 64 * hold) begin
                rxd = stopv;
            end else begin
                rxd = 1'b1;
            end
            r_ack = (c == ack_off);
            prev  = rda;
            @(posedge clk);
            #2;
            if (rda && !prev && last_rise < 0) last_rise = c;
        end
        r_ack = 1'b0;
        rxd   = 1'b1;
    endtask

    task automatic model_ack();
        m_rda  = 1'b0;
        m_ferr = 1'b0;
        m_oerr = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stopv);
        m_oerr = m_rda;
        m_rda  = 1'b1;
        m_data = b;
        m_ferr = ~stopv;
    endtask

    initial begin
        logic [7:0] rb;
        logic       rs;
        int         rh;

        tbl[0] = '{8'hA5, 1'b1, 0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b0, 2, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{8'h11, 1'b1, 0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{8'h22, 1'b1, 0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{8'h5A, 1'b0, 0, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b1};
        tbl[5] = '{8'h0F, 1'b1, 0, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0};

        rst   = 1'b0;
        rxd   = 1'b1;
        r_ack = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        idle(20);

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].ack) pulse_ack();
            drive_frame(tbl[i].b, tbl[i].stopv, tbl[i].hold, -1, -1);
            if (i == 0) begin
                lat_ref = last_rise;
                check_range("stop_latency", lat_ref, 600, 624);
            end
            check_outputs($sformatf("vec%0d", i), tbl[i].e_data, tbl[i].e_rda,
                          tbl[i].e_ferr, tbl[i].e_oerr);
        end

        // r_ack clears every flag on the next edge, data is kept
        pulse_ack();
        check_outputs("ack_clear", 8'h0F, 1'b0, 1'b0, 1'b0);
        pulse_ack();
        check_outputs("ack_idle", 8'h0F, 1'b0, 1'b0, 1'b0);

        // break: stop bit low and line held low, must not yield a second frame
        drive_frame(8'h3C, 1'b0, 2, -1, -1);
        check_outputs("break", 8'h3C, 1'b1, 1'b1, 1'b0);
        pulse_ack();
        idle(200);
        check("no_second_frame", 32'(rda), 32'(0));

        // false start: low for 3 baud ticks only
        @(posedge clk);
        #2;
        while (bcnt % 4 != 0) begin
            @(posedge clk);
            #2;
        end
        rxd = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #2;
        end
        idle(200);
        check("false_start_rda", 32'(rda), 32'(0));
        drive_frame(8'h5A, 1'b1, 0, -1, -1);
        check_outputs("after_false", 8'h5A, 1'b1, 1'b0, 1'b0);

        // reset in data bit 4 of 0xFF
        drive_frame(8'hFF, 1'b1, 0, -1, 5 * 64 + 32);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #2;
        end
        check_outputs("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rxd = 1'b1;
        rst = 1'b1;
        idle(100);
        drive_frame(8'hFE, 1'b1, 0, -1, -1);
        check_outputs("post_reset", 8'hFE, 1'b1, 1'b0, 1'b0);

        // r_ack coincident with the stop-sample edge of a second frame
        pulse_ack();
        drive_frame(8'h55, 1'b1, 0, -1, -1);
        check_outputs("first_of_pair", 8'h55, 1'b1, 1'b0, 1'b0);
        drive_frame(8'h80, 1'b1, 0, lat_ref, -1);
        check_outputs("ack_collide", 8'h80, 1'b1, 1'b0, 1'b0);

        // randomized frames against the frame-level model
        pulse_ack();
        m_data = 8'h80;
        model_ack();
        for (int k = 0; k < 24; k++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            rh = rs ? 0 : int'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) begin
                pulse_ack();
                model_ack();
            end
            drive_frame(rb, rs, rh, -1, -1);
            model_frame(rb, rs);
            check_outputs($sformatf("rand%0d", k), m_data, m_rda, m_ferr, m_oerr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
